t05_bit_packer: RTL and testbench

Serial-to-byte packer directly downstream of `t05_translation`. Consumes the Huffman-encoded bit stream (`writeBin`) one bit per accepted cycle and assembles MSB-first bytes. Buffers finished bytes in a small FIFO and hands them to the SRAM/SPI write stage over a valid/ready handshake. On end of file it zero-pads the final partial byte and reports the pad count for the compressed-file header.

---
 rtl/t05_pack_pkg.sv | 21 ++
 rtl/t05_byte_fifo.sv | 66 ++++++
 rtl/t05_bit_packer.sv | 158 +++++++++++++++
 tb/tb_t05_bit_packer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t05_pack_pkg.sv
// Shared types and defaults for the t05 bit packer.
// The enum, default widths and the pad_bits width helper live here so the
// top level and any future users agree on them.
package t05_pack_pkg;

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pack_state_t;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // pad_bits must be able to represent 0..word_w inclusive
  function automatic int pad_width(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/t05_byte_fifo.sv
// Small synchronous FIFO with a show-ahead head word.
// head is forced to zero while empty so the downstream bus never shows
// stale data. DEPTH must be a power of two so the pointers wrap for free.
module t05_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array is written only on an accepted push; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping, restartable by clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/t05_bit_packer.sv
// Serial-to-word packer behind the Huffman translation stage.
// Bits arrive MSB-first, finished words queue in t05_byte_fifo, and on flush
// the last partial word is zero-padded with the pad count reported.
// Optional feature: define T05_PACKER_BYTECOUNT_EN to add the byte_count port.
module t05_bit_packer
  import t05_pack_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           clear,
  input  logic                           bit_in,
  input  logic                           bit_valid,
  output logic                           bit_ready,
  input  logic                           flush,
  output logic [WORD_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [pad_width(WORD_W)-1:0]   pad_bits,
  output logic                           done
`ifdef T05_PACKER_BYTECOUNT_EN
  ,
  output logic [31:0]                    byte_count
`endif
);

  localparam int PAD_W = pad_width(WORD_W);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  pack_state_t       state;
  logic [PAD_W-1:0]  cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] shift_next;
  logic [IDX_W-1:0]  bit_idx;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              last_bit;
  logic              push;
  logic              pop;

  // Stalling only on the word-completing bit keeps throughput at one bit per
  // cycle; the stall depends on registered state only, never on out_ready.
  assign last_bit  = (cnt == PAD_W'(WORD_W - 1));
  assign bit_ready = (state == PACK) && (!last_bit || !fifo_full);
  assign accept    = bit_valid && bit_ready;
  assign bit_idx   = IDX_W'(WORD_W - 1) - IDX_W'(cnt);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Word image including the bit being accepted this cycle
  always_comb begin
    shift_next = shift_reg;
    if (accept) begin
      shift_next[bit_idx] = bit_in;
    end
  end

  // FIFO push: a completed word while packing, or the padded tail in FLUSH
  always_comb begin
    push = 1'b0;
    if (!clear) begin
      case (state)
        PACK:    push = accept && last_bit;
        FLUSH:   push = (cnt != '0) && !fifo_full;
        default: push = 1'b0;
      endcase
    end
  end

  t05_byte_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (clear),
    .push      (push),
    .push_data (shift_next),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Packer FSM with shift register, bit counter and registered status outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= PACK;
      cnt       <= '0;
      shift_reg <= '0;
      pad_bits  <= '0;
      done      <= 1'b0;
    end else if (clear) begin
      state     <= PACK;
      cnt       <= '0;
      shift_reg <= '0;
      pad_bits  <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        PACK: begin
          if (accept) begin
            if (last_bit) begin
              cnt       <= '0;
              shift_reg <= '0;
            end else begin
              cnt       <= cnt + 1'b1;
              shift_reg <= shift_next;
            end
          end
          if (flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            pad_bits <= '0;
            state    <= DRAIN;
          end else if (!fifo_full) begin
            pad_bits  <= PAD_W'(WORD_W) - cnt;
            cnt       <= '0;
            shift_reg <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= PACK;
        end
      endcase
    end
  end

`ifdef T05_PACKER_BYTECOUNT_EN
  // Count of every word pushed, padded tail included
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byte_count <= '0;
    end else if (clear) begin
      byte_count <= '0;
    end else if (push) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_t05_bit_packer.sv
// Self-checking bench for t05_bit_packer (default WORD_W=8, FIFO_DEPTH=4).
// Expected words are queued as bits are driven and checked on each handshake.
module tb_t05_bit_packer;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       clear = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       bit_ready;
  logic       out_valid;
  logic       done;
  logic [7:0] out_data;
  logic [3:0] pad_bits;
`ifdef T05_PACKER_BYTECOUNT_EN
  logic [31:0] byte_count;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  t05_bit_packer dut (
    .clk       (clk),
    .nrst      (nrst),
    .clear     (clear),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pad_bits  (pad_bits),
    .done      (done)
`ifdef T05_PACKER_BYTECOUNT_EN
    ,
    .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every handshake seen at the falling edge completes on the next rise
  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL word_unexpected: got %h, expected no word", out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if (out_data !== exp_word) begin
          errors++;
          $display("[TB] FAIL word_data: got %h, expected %h", out_data, exp_word);
        end
      end
    end
  end

  // Drive one bit and hold it until accepted; called and returns at posedge+1
  task automatic send_bit(input logic b);
    int waited = 0;
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    while (!bit_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bit_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL bit_accept_timeout: bit_ready got %b, expected 1", bit_ready);
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  // Send the top n bits of w, MSB first
  task automatic send_byte(input logic [7:0] w, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      send_bit(w[i]);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_timeout: got %b, expected 1", done);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data: got %h, expected 00", out_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
    checks++; if (pad_bits !== 4'd0) begin errors++; $display("[TB] FAIL reset_pad_bits: got %0d, expected 0", pad_bits); end
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_bit_ready: got %b, expected 1", bit_ready); end
`ifdef T05_PACKER_BYTECOUNT_EN
    checks++; if (byte_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_byte_count: got %0d, expected 0", byte_count); end
`endif
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    exp_q.push_back(8'hA1);
    send_byte(8'hA1, 8);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid_rise: got %b, expected 1", out_valid); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_fall: got %b, expected 0", out_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL single_popped: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_flush_partial();
    out_ready = 1'b1;
    exp_q.push_back(8'hB3);
    exp_q.push_back(8'hA0);
    send_byte(8'hB3, 8);
    send_byte(8'hA0, 3);
    pulse_flush();
    wait_done();
    checks++; if (pad_bits !== 4'd5) begin errors++; $display("[TB] FAIL flush_pad_bits: got %0d, expected 5", pad_bits); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL flush_words: got %0d pending, expected 0", exp_q.size()); end
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL done_bit_ready: got %b, expected 0", bit_ready); end
  endtask

  task automatic test_clear();
    pulse_clear();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL clear_done: got %b, expected 0", done); end
    checks++; if (pad_bits !== 4'd0) begin errors++; $display("[TB] FAIL clear_pad_bits: got %0d, expected 0", pad_bits); end
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_bit_ready: got %b, expected 1", bit_ready); end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [5];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom_range(0, 255));
      exp_q.push_back(w[i]);
    end
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i], 8);
    end
    send_byte(w[4], 7);
    bit_in    = w[4][0];
    bit_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bit_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_bit_ready: got %b, expected 0", bit_ready); end
      checks++; if (out_data !== w[0]) begin errors++; $display("[TB] FAIL stall_head: got %h, expected %h", out_data, w[0]); end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_bit(w[4][0]);
    wait_drain();
  endtask

  task automatic test_flush_aligned();
    out_ready = 1'b1;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    send_byte(8'hC3, 8);
    send_byte(8'h5A, 8);
    pulse_flush();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL aligned_done_c1: got %b, expected 0", done); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL aligned_done_c2: got %b, expected 0", done); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL aligned_done_c3: got %b, expected 1", done); end
    checks++; if (pad_bits !== 4'd0) begin errors++; $display("[TB] FAIL aligned_pad_bits: got %0d, expected 0", pad_bits); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL aligned_words: got %0d pending, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_byte();
    pulse_clear();
    out_ready = 1'b1;
    send_byte(8'b1011_0000, 5);
    nrst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid: got %b, expected 0", out_valid); end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bit_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_bit_ready: got %b, expected 1", bit_ready); end
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 8);
    wait_drain();
  endtask

  task automatic test_byte_count();
    pulse_clear();
    out_ready = 1'b1;
    exp_q.push_back(8'hAB);
    exp_q.push_back(8'hCD);
    exp_q.push_back(8'hE0);
    send_byte(8'hAB, 8);
    send_byte(8'hCD, 8);
    send_byte(8'hE0, 4);
    pulse_flush();
    wait_done();
    checks++; if (pad_bits !== 4'd4) begin errors++; $display("[TB] FAIL count_pad_bits: got %0d, expected 4", pad_bits); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL count_words: got %0d pending, expected 0", exp_q.size()); end
`ifdef T05_PACKER_BYTECOUNT_EN
    checks++; if (byte_count !== 32'd3) begin errors++; $display("[TB] FAIL byte_count_value: got %0d, expected 3", byte_count); end
`endif
    pulse_clear();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL count_clear_done: got %b, expected 0", done); end
`ifdef T05_PACKER_BYTECOUNT_EN
    checks++; if (byte_count !== 32'd0) begin errors++; $display("[TB] FAIL byte_count_clear: got %0d, expected 0", byte_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_flush_partial();
    test_clear();
    test_backpressure();
    test_flush_aligned();
    test_reset_mid_byte();
    test_byte_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so a wedged design still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
